// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with registered read data and occupancy-decoded
// status flags; storage block behind the FIFO bus interface.
module modport_fifo #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 16,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AF_TH = (AW+1)'(ALMOST_FULL_TH);
    localparam logic [AW:0] C_AE_TH = (AW+1)'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    logic w_rd_acc;
    logic w_wr_acc;

    // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
    assign w_rd_acc = rd_en & ~fifo_empty;
    assign w_wr_acc = wr_en & (~fifo_full | w_rd_acc);

    assign fifo_full         = (r_count == C_DEPTH);
    assign fifo_empty        = (r_count == '0);
    assign fifo_almost_full  = (r_count >= C_AF_TH);
    assign fifo_almost_empty = (r_count <= C_AE_TH);

    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            data_out <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc) begin
                data_out <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_acc && !w_rd_acc)
                r_count <= r_count + (AW+1)'(1);
            else if (w_rd_acc && !w_wr_acc)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage is not reset; when full, rd_ptr == wr_ptr and the read sees the old word.
    always_ff @(posedge wr_clk) begin
        if (w_wr_acc && reset)
            r_mem[r_wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_modport_fifo.sv
// Directed + randomized bench for modport_fifo, checked against a queue model.
module tb_modport_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF_TH = 14;
    localparam int AE_TH = 2;

    logic          wr_clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;

    modport_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)
    ) dut (
        .wr_clk(wr_clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty)
    );

    always #5 wr_clk = ~wr_clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int occ;
        occ = q.size();
        chk({tag, ".dout"}, data_out, exp_dout);
        chk({tag, ".full"}, DW'(fifo_full), DW'(occ == DEPTH));
        chk({tag, ".empty"}, DW'(fifo_empty), DW'(occ == 0));
        chk({tag, ".afull"}, DW'(fifo_almost_full), DW'(occ >= AF_TH));
        chk({tag, ".aempty"}, DW'(fifo_almost_empty), DW'(occ <= AE_TH));
    endtask

    // One clock of traffic; the model advances from its pre-edge occupancy.
    task automatic step(input string tag, input logic we, input logic re, input logic [DW-1:0] din);
        bit racc, wacc;
        @(negedge wr_clk);
        wr_en = we; rd_en = re; data_in = din;
        @(posedge wr_clk);
        racc = re && (q.size() > 0);
        wacc = we && ((q.size() < DEPTH) || racc);
        if (racc) exp_dout = q.pop_front();
        if (wacc) q.push_back(din);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        exp_dout = '0;
        repeat (3) @(posedge wr_clk);
        #1;
        check_all("reset");
        @(negedge wr_clk);
        reset = 1'b1;

        // Fill with 1..16, then a dropped write while full, then drain.
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, DW'(i));
        step("ovf", 1'b1, 1'b0, 32'hDEAD_BEEF);
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain", 1'b0, 1'b1, '0);
            chk("drain_order", data_out, DW'(i));
        end

        // Read while empty holds data_out; count stays zero.
        step("udf", 1'b0, 1'b1, '0);
        chk("udf_hold", data_out, 32'h0000_0010);

        // Simultaneous access at full: A5A5A5A5 must be the 16th word out.
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 1'b0, 32'h100 + DW'(i));
        step("full_rw", 1'b1, 1'b1, 32'hA5A5_A5A5);
        chk("full_rw_out", data_out, 32'h100);
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b1, '0);
        chk("a5_last", data_out, 32'hA5A5_A5A5);

        // Simultaneous access at empty: write lands, read ignored.
        step("empty_rw", 1'b1, 1'b1, 32'h0BAD_F00D);
        chk("empty_rw_dout", data_out, 32'hA5A5_A5A5);
        step("empty_rw_out", 1'b0, 1'b1, '0);
        chk("empty_rw_val", data_out, 32'h0BAD_F00D);

        // Wrap-around at steady occupancy 3.
        for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, 1'b1, $urandom);
        for (int i = 0; i < 3; i++) step("wrap_post", 1'b0, 1'b1, '0);

        // Random traffic with phases biased toward full and toward empty.
        for (int i = 0; i < 300; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 75 : 25;
            step("rand", ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < 100 - wp), $urandom);
        end

        // Mid-operation reset between edges.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, 32'hC0DE_0000 + DW'(i));
        @(negedge wr_clk);
        wr_en = 1'b0; rd_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        q.delete();
        exp_dout = '0;
        check_all("midrst");
        #1 reset = 1'b1;
        step("post_wr", 1'b1, 1'b0, 32'h1234_5678);
        step("post_rd", 1'b0, 1'b1, '0);
        chk("post_val", data_out, 32'h1234_5678);
        step("post_empty", 1'b0, 1'b1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modport_fifo.md
Name: modport_fifo

Overview:
- Single-clock synchronous 32-bit FIFO that serves as the storage block behind the FIFO bus interface.
- Drivers push through wr_en/data_in and pop through rd_en/data_out.
- Monitors sample the full, empty, almost_full and almost_empty status flags.
- Both read and write ports are clocked on wr_clk.

Parameters:
- DATA_WIDTH, 32, width of data_in and data_out.
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- ALMOST_FULL_TH, 14, fifo_almost_full asserts when occupancy >= this value.
- ALMOST_EMPTY_TH, 2, fifo_almost_empty asserts when occupancy <= this value.

Ports:
- wr_clk  input  1  the single clock; all reads and writes sample on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- fifo_full  output  1  occupancy == DEPTH.
- fifo_empty  output  1  occupancy == 0.
- fifo_almost_full  output  1  occupancy >= ALMOST_FULL_TH.
- fifo_almost_empty  output  1  occupancy <= ALMOST_EMPTY_TH.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Ports are named wr_clk and reset.
- Reset (reset=0, takes effect immediately, no clock needed):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0.
  - fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0.
  - Memory contents need not be cleared.
- State:
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrap from DEPTH-1 to 0.
  - count, log2(DEPTH)+1 bits, ranges 0..DEPTH.
- Write accept: wr_acc = wr_en & (!fifo_full | rd_acc).
  - On accept: mem[wr_ptr] <= data_in and wr_ptr increments on the same edge.
- Read accept: rd_acc = rd_en & !fifo_empty.
  - On accept: data_out <= mem[rd_ptr] and rd_ptr increments.
  - Data is valid on data_out after that edge, i.e. 1-cycle latency.
  - No fall-through: a word written at edge N is readable at the earliest at edge N+1.
- data_out holds its last value when no read is accepted, including reads attempted while empty.
- Count update on each edge:
  - +1 if wr_acc only.
  - -1 if rd_acc only.
  - unchanged if both or neither.
- Boundary cases:
  - Write while full with no read: dropped; memory, pointers and count unchanged.
  - Write and read together while full: both accepted; count stays DEPTH.
  - Read while empty: ignored; a simultaneous write is still accepted and count becomes 1.
  - Read while empty never underflows count.
- Flags:
  - Combinational decode of the registered count, so each flag changes on the same edge as count.
  - Flags are glitch-free relative to the clock.
- Reset asserted mid-operation: discards all stored data immediately and returns every output to its reset value.
- Operation resumes on the first rising edge after reset deasserts.

Test Plan:
- Reset check: hold reset=0 for 3 cycles → data_out=0, fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0.
- Fill and drain:
  - Write 0x0000_0001..0x0000_0010 on 16 consecutive cycles → fifo_almost_empty drops after the 3rd write, fifo_almost_full rises after the 14th, fifo_full rises after the 16th.
  - Then 16 reads → data_out returns 0x01..0x10 in order, one cycle after each rd_en; fifo_empty=1 at the end.
- Overflow and underflow:
  - With the FIFO full, write 0xDEAD_BEEF → ignored; the subsequent drain contains no 0xDEADBEEF.
  - With the FIFO empty, assert rd_en → data_out holds its last value and count stays 0.
- Simultaneous access:
  - Full FIFO, wr_en=rd_en=1 with 0xA5A5_A5A5 → fifo_full stays 1; 0xA5A5A5A5 emerges as the 16th read.
  - Empty FIFO, wr_en=rd_en=1 → count becomes 1, fifo_empty=0.
- Wrap-around: run 40 interleaved write/read cycles at occupancy 3 → all values come out in order with no loss across pointer wrap.
- Mid-operation reset: write 5 words, pulse reset low between clock edges → outputs return to reset values immediately; the next write/read pair returns the new value only.
